// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: FSM encoding, frame bit positions and default timing
// used by both the host transmitter and the keyboard receiver.
package ps2_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INHIBIT,
    ST_REQ,
    ST_SHIFT,
    ST_ACK,
    ST_WAIT_IDLE
  } ps2_state_e;

  localparam logic [3:0] FRAME_START  = 4'd0;
  localparam logic [3:0] FRAME_PARITY = 4'd9;
  localparam logic [3:0] FRAME_STOP   = 4'd10;

  localparam int unsigned DEF_CLK_HZ         = 50_000_000;
  localparam int unsigned DEF_INHIBIT_CYCLES = 5000;
  localparam int unsigned DEF_SETUP_CYCLES   = 50;
  localparam int unsigned DEF_TIMEOUT_CYCLES = 750_000;

  // Frame index 0..10: start(0), data LSB first, odd parity, stop(1).
  function automatic logic [10:0] ps2_frame(input logic [7:0] data);
    logic [10:0] f;
    f                   = '0;
    f[FRAME_START]      = 1'b0;
    f[8:1]              = data;
    f[FRAME_PARITY]     = ~^data;
    f[FRAME_STOP]       = 1'b1;
    return f;
  endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// Two-flop synchronizer for one PS/2 pad input plus a falling-edge detector
// on the synchronized history ({older, newer} == 2'b10).
module ps2_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic line_in,
  output logic line_s,
  output logic fall
);

  logic [2:0] sh_q;
  logic [2:0] sh_d;

  always_comb begin
    sh_d = {sh_q[1:0], line_in};
  end

  always_ff @(posedge clk) begin
    if (rst) sh_q <= 3'b111;
    else     sh_q <= sh_d;
  end

  assign line_s = sh_q[1];
  assign fall   = (sh_q[2:1] == 2'b10);

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibits the clock, requests to send, then
// shifts an 11-bit frame on device-generated falling edges and checks the ack.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int unsigned CLK_HZ         = DEF_CLK_HZ,
  parameter int unsigned INHIBIT_CYCLES = DEF_INHIBIT_CYCLES,
  parameter int unsigned SETUP_CYCLES   = DEF_SETUP_CYCLES,
  parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       done,
  output logic       err
);

  localparam int unsigned CNT_MAX_A = (INHIBIT_CYCLES > SETUP_CYCLES) ? INHIBIT_CYCLES : SETUP_CYCLES;
  localparam int unsigned CNT_MAX   = (CNT_MAX_A > TIMEOUT_CYCLES) ? CNT_MAX_A : TIMEOUT_CYCLES;
  localparam int unsigned CNT_W     = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] INHIBIT_LAST = CNT_W'(INHIBIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETUP_LAST   = CNT_W'(SETUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  // The board frequency only documents how the default cycle counts were derived.
  logic [31:0] clk_hz_unused;
  assign clk_hz_unused = CLK_HZ;

  logic clk_s, clk_fall;
  logic data_s, data_fall_unused;

  ps2_sync_edge u_sync_clk (
    .clk     (clk),
    .rst     (rst),
    .line_in (ps2_clk),
    .line_s  (clk_s),
    .fall    (clk_fall)
  );

  ps2_sync_edge u_sync_data (
    .clk     (clk),
    .rst     (rst),
    .line_in (ps2_data),
    .line_s  (data_s),
    .fall    (data_fall_unused)
  );

  ps2_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       bitcnt_q, bitcnt_d;
  logic [10:0]      frame_q, frame_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q + CNT_W'(1);
    bitcnt_d    = bitcnt_q;
    frame_d     = frame_q;
    done_d      = 1'b0;
    err_d       = 1'b0;
    tx_ready    = 1'b0;
    ps2_clk_oe  = 1'b0;
    ps2_data_oe = 1'b0;

    case (state_q)
      ST_IDLE: begin
        tx_ready = 1'b1;
        cnt_d    = '0;
        bitcnt_d = FRAME_START;
        if (tx_valid) begin
          frame_d = ps2_frame(tx_data);
          state_d = ST_INHIBIT;
        end
      end
      ST_INHIBIT: begin
        ps2_clk_oe = 1'b1;
        if (cnt_q == INHIBIT_LAST) begin
          cnt_d   = '0;
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        ps2_clk_oe  = 1'b1;
        ps2_data_oe = 1'b1;
        if (cnt_q == SETUP_LAST) begin
          cnt_d    = '0;
          bitcnt_d = FRAME_START;
          state_d  = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        ps2_data_oe = ~frame_q[bitcnt_q];
        if (clk_fall) begin
          cnt_d    = '0;
          bitcnt_d = bitcnt_q + 4'd1;
          // Stop bit is a released line, so ACK keeps data_oe low.
          if (bitcnt_q == FRAME_STOP - 4'd1) state_d = ST_ACK;
        end else if (cnt_q == TIMEOUT_LAST) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end
      end
      ST_ACK: begin
        if (clk_fall) begin
          cnt_d = '0;
          if (!data_s) begin
            state_d = ST_WAIT_IDLE;
          end else begin
            err_d   = 1'b1;
            state_d = ST_IDLE;
          end
        end else if (cnt_q == TIMEOUT_LAST) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end
      end
      ST_WAIT_IDLE: begin
        if (clk_s && data_s) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end else if (clk_fall) begin
          cnt_d = '0;
        end else if (cnt_q == TIMEOUT_LAST) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      bitcnt_q <= FRAME_START;
      frame_q  <= '1;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bitcnt_q <= bitcnt_d;
      frame_q  <= frame_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign done = done_q;
  assign err  = err_q;

endmodule
